// File: rtl/sim_frame_sequencer.sv
// ============================================================================
// Module   : sim_frame_sequencer
// Purpose  : Gates the location walk so one full screen pass is written per
//            trigger (free-run, game-clock step, key single-step, key burst).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sim_frame_sequencer #(
    parameter int X_BITS     = 10,
    parameter int Y_BITS     = 9,
    parameter int LAST_X     = 639,
    parameter int LAST_Y     = 479,
    parameter int BURST_BITS = 8,
    parameter int FRAME_BITS = 16
) (
    input  logic                  newLocClock,
    input  logic                  RUN,
    input  logic                  game_clock,
    input  logic                  KEY_PAUSE,
    input  logic [1:0]            mode,
    input  logic [BURST_BITS-1:0] burst_len,
    input  logic [X_BITS-1:0]     writeLoc_x,
    input  logic [Y_BITS-1:0]     writeLoc_y,
    output logic                  write_flag,
    output logic                  hold_locs,
    output logic                  frame_done,
    output logic [FRAME_BITS-1:0] frame_count,
    output logic                  waiting
);

    localparam logic [X_BITS-1:0] c_last_x = X_BITS'(LAST_X);
    localparam logic [Y_BITS-1:0] c_last_y = Y_BITS'(LAST_Y);

    typedef enum logic [1:0] {
        S_INIT  = 2'd0,
        S_WRITE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t                r_state;
    logic                  r_write_flag;
    logic                  r_hold_locs;
    logic                  r_waiting;
    logic [FRAME_BITS-1:0] r_frame_count;
    logic [BURST_BITS-1:0] r_burst_rem;

    logic [1:0] r_gc_sync;
    logic       r_gc_prev;
    logic       r_gc_rise;
    logic [1:0] r_key_sync;
    logic       r_key_prev;
    logic       r_key_rel;

    logic                  w_last_loc;
    logic                  w_trigger;
    logic [BURST_BITS-1:0] w_burst_load;

    assign w_last_loc   = (writeLoc_x == c_last_x) && (writeLoc_y == c_last_y);
    assign w_burst_load = (burst_len == '0) ? '0 : burst_len - 1'b1;
    assign w_trigger    = (mode == 2'd0) ||
                          ((mode == 2'd1) && r_gc_rise) ||
                          (mode[1] && r_key_rel);

    // Two-flop synchronisers followed by a registered edge detector; the key
    // idles high (released) so its chain resets to 1.
    always_ff @(posedge newLocClock or negedge RUN) begin
        if (!RUN) begin
            r_gc_sync  <= 2'b00;
            r_gc_prev  <= 1'b0;
            r_gc_rise  <= 1'b0;
            r_key_sync <= 2'b11;
            r_key_prev <= 1'b1;
            r_key_rel  <= 1'b0;
        end else begin
            r_gc_sync  <= {r_gc_sync[0], game_clock};
            r_gc_prev  <= r_gc_sync[1];
            r_gc_rise  <= r_gc_sync[1] & ~r_gc_prev;
            r_key_sync <= {r_key_sync[0], KEY_PAUSE};
            r_key_prev <= r_key_sync[1];
            r_key_rel  <= r_key_sync[1] & ~r_key_prev;
        end
    end

    always_ff @(posedge newLocClock or negedge RUN) begin
        if (!RUN) begin
            r_state       <= S_INIT;
            r_write_flag  <= 1'b0;
            r_hold_locs   <= 1'b0;
            r_waiting     <= 1'b0;
            r_frame_count <= '0;
            r_burst_rem   <= '0;
        end else begin
            case (r_state)
                S_INIT: begin
                    if (w_last_loc) begin
                        r_state      <= S_WRITE;
                        r_write_flag <= 1'b1;
                        r_burst_rem  <= w_burst_load;
                    end
                end
                S_WRITE: begin
                    if (w_last_loc) begin
                        r_frame_count <= r_frame_count + 1'b1;
                        if (mode == 2'd0) begin
                            r_state <= S_WRITE;
                        end else if ((mode == 2'd3) && (r_burst_rem != '0)) begin
                            r_burst_rem <= r_burst_rem - 1'b1;
                        end else begin
                            r_state      <= S_WAIT;
                            r_write_flag <= 1'b0;
                            r_hold_locs  <= 1'b1;
                            r_waiting    <= 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    if (w_trigger) begin
                        r_state      <= S_WRITE;
                        r_write_flag <= 1'b1;
                        r_hold_locs  <= 1'b0;
                        r_waiting    <= 1'b0;
                        if (mode == 2'd3) begin
                            r_burst_rem <= w_burst_load;
                        end
                    end
                end
                default: begin
                    r_state      <= S_INIT;
                    r_write_flag <= 1'b0;
                    r_hold_locs  <= 1'b0;
                    r_waiting    <= 1'b0;
                end
            endcase
        end
    end

    // Same-cycle pulse so the final location of the pass is still written.
    assign frame_done  = (r_state == S_WRITE) && w_last_loc;
    assign write_flag  = r_write_flag;
    assign hold_locs   = r_hold_locs;
    assign waiting     = r_waiting;
    assign frame_count = r_frame_count;

endmodule

`default_nettype wire

// File: tb/tb_sim_frame_sequencer.sv
// ============================================================================
// Module   : tb_sim_frame_sequencer
// Purpose  : Scoreboard bench for sim_frame_sequencer on a 4x3 location walk.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sim_frame_sequencer;

    localparam int c_fb = 4;

    logic            newLocClock = 1'b0;
    logic            RUN         = 1'b0;
    logic            game_clock  = 1'b0;
    logic            KEY_PAUSE   = 1'b1;
    logic [1:0]      mode        = 2'd1;
    logic [7:0]      burst_len   = 8'd3;
    logic [1:0]      loc_x       = 2'd0;
    logic [1:0]      loc_y       = 2'd0;
    logic            write_flag;
    logic            hold_locs;
    logic            frame_done;
    logic [c_fb-1:0] frame_count;
    logic            waiting;

    int n_checks = 0;
    int n_fail   = 0;
    int n_writes = 0;
    int exp_cnt  = 0;
    logic [c_fb-1:0] sb_q[$];

    sim_frame_sequencer #(
        .X_BITS(2), .Y_BITS(2), .LAST_X(3), .LAST_Y(2),
        .BURST_BITS(8), .FRAME_BITS(c_fb)
    ) dut (
        .newLocClock(newLocClock), .RUN(RUN), .game_clock(game_clock),
        .KEY_PAUSE(KEY_PAUSE), .mode(mode), .burst_len(burst_len),
        .writeLoc_x(loc_x), .writeLoc_y(loc_y), .write_flag(write_flag),
        .hold_locs(hold_locs), .frame_done(frame_done),
        .frame_count(frame_count), .waiting(waiting)
    );

    always #5 newLocClock = ~newLocClock;

    // Location generator model: 4x3 raster walk that freezes on hold_locs.
    always @(posedge newLocClock) begin
        if (!RUN) begin
            loc_x <= 2'd0;
            loc_y <= 2'd0;
        end else if (!hold_locs) begin
            if (loc_x == 2'd3) begin
                loc_x <= 2'd0;
                loc_y <= (loc_y == 2'd2) ? 2'd0 : loc_y + 2'd1;
            end else begin
                loc_x <= loc_x + 2'd1;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge newLocClock);
            #1;
        end
    endtask

    task automatic push_pass();
        sb_q.push_back(c_fb'(exp_cnt));
        exp_cnt++;
    endtask

    // Monitor: samples on the falling edge, stimulus acts 1 time unit later.
    always @(negedge newLocClock) begin
        if (write_flag) n_writes++;
        if (frame_done) begin
            if (sb_q.size() == 0) begin
                check("unexpected_frame_done", 1, 0);
            end else begin
                check("frame_count_at_done", int'(frame_count), int'(sb_q.pop_front()));
                check("done_location", int'({loc_x, loc_y}), int'({2'd3, 2'd2}));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        int bad;
        int found;

        // Reset state, then mode 1 with no game_clock edge
        step(3);
        check("rst_write_flag", int'(write_flag), 0);
        check("rst_hold_locs", int'(hold_locs), 0);
        check("rst_waiting", int'(waiting), 0);
        check("rst_frame_done", int'(frame_done), 0);
        check("rst_frame_count", int'(frame_count), 0);
        push_pass();
        RUN = 1'b1;
        check("first_cycle_write_flag", int'(write_flag), 0);
        step(30);
        check("p1_writes", n_writes, 12);
        check("p1_frame_count", int'(frame_count), 1);
        check("p1_hold", int'(hold_locs), 1);
        check("p1_waiting", int'(waiting), 1);
        step(30);
        check("p1_still_writes", n_writes, 12);
        check("p1_still_hold", int'(hold_locs), 1);

        // Mode 1: game_clock edge, latency 4, second edge ignored
        w0 = n_writes;
        push_pass();
        game_clock = 1'b1;
        step(3);
        check("gc_latency_pre", int'(write_flag), 0);
        step(1);
        check("gc_latency_at4", int'(write_flag), 1);
        game_clock = 1'b0;
        step(2);
        game_clock = 1'b1;
        step(25);
        check("p2_writes", n_writes - w0, 12);
        check("p2_frame_count", int'(frame_count), 2);
        check("p2_waiting", int'(waiting), 1);
        game_clock = 1'b0;

        // Mode 2: holding the key does nothing, each release one pass
        mode = 2'd2;
        w0 = n_writes;
        KEY_PAUSE = 1'b0;
        step(20);
        check("p3_held_no_pass", n_writes - w0, 0);
        for (int r = 0; r < 3; r++) begin
            push_pass();
            KEY_PAUSE = 1'b1;
            step(25);
            KEY_PAUSE = 1'b0;
            step(5);
        end
        check("p3_writes", n_writes - w0, 36);
        check("p3_frame_count", int'(frame_count), exp_cnt % 16);

        // Mode 3: burst of 3 back-to-back passes
        mode = 2'd3;
        burst_len = 8'd3;
        push_pass(); push_pass(); push_pass();
        KEY_PAUSE = 1'b1;
        step(4);
        bad = 0;
        for (int i = 0; i < 36; i++) begin
            if (!write_flag || hold_locs) bad++;
            step(1);
        end
        check("burst3_continuous", bad, 0);
        check("burst3_waiting", int'(waiting), 1);
        check("burst3_frame_count", int'(frame_count), exp_cnt % 16);

        // burst_len 0 behaves as 1
        burst_len = 8'd0;
        w0 = n_writes;
        KEY_PAUSE = 1'b0;
        step(3);
        push_pass();
        KEY_PAUSE = 1'b1;
        step(25);
        check("burst0_writes", n_writes - w0, 12);
        check("burst0_waiting", int'(waiting), 1);

        // Mode 0: free-run, then switch to mode 2 mid-pass
        for (int p = 0; p < 5; p++) push_pass();
        w0 = n_writes;
        mode = 2'd0;
        step(1);
        bad = 0;
        for (int i = 0; i < 48; i++) begin
            if (hold_locs) bad++;
            if (int'(frame_done) != int'((i % 12) == 11)) bad++;
            step(1);
        end
        check("free_run_cadence", bad, 0);
        found = 0;
        for (int i = 0; i < 20; i++) begin
            if (loc_x == 2'd1 && loc_y == 2'd1) begin
                found = 1;
                break;
            end
            step(1);
        end
        check("reached_loc_1_1", found, 1);
        mode = 2'd2;
        step(15);
        check("free_run_writes", n_writes - w0, 60);
        check("free_run_stop_waiting", int'(waiting), 1);

        // RUN low mid-pass at (2,1)
        KEY_PAUSE = 1'b0;
        step(3);
        KEY_PAUSE = 1'b1;
        found = 0;
        for (int i = 0; i < 30; i++) begin
            if (write_flag && loc_x == 2'd2 && loc_y == 2'd1) begin
                found = 1;
                break;
            end
            step(1);
        end
        check("reached_loc_2_1", found, 1);
        RUN = 1'b0;
        #1;
        check("async_write_flag", int'(write_flag), 0);
        check("async_hold_locs", int'(hold_locs), 0);
        check("async_waiting", int'(waiting), 0);
        check("async_frame_done", int'(frame_done), 0);
        check("async_frame_count", int'(frame_count), 0);
        step(1);
        RUN = 1'b1;
        mode = 2'd0;
        exp_cnt = 0;
        for (int p = 0; p < 16; p++) push_pass();
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            if (write_flag) bad++;
            step(1);
        end
        check("reinit_no_write", bad, 0);
        check("reinit_then_write", int'(write_flag), 1);
        step(180);
        mode = 2'd2;
        step(15);
        check("frame_count_wrap", int'(frame_count), 0);
        check("wrap_waiting", int'(waiting), 1);
        check("scoreboard_drained", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
